// File: rtl/store_unit_pkg.sv
// Shared types and constants for the store path.
// Optional feature macro used by this slice: STORE_MISALIGN_SPLIT_EN.
package store_unit_pkg;

  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } store_state_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational narrowing and byte-lane placement of store data.
// Produces a two-word image so word-crossing stores show up in the upper half.
module store_lane_align
  import store_unit_pkg::*;
(
  input  logic [1:0]                size,
  input  logic [1:0]                off,
  input  logic [31:0]               data,
  output logic [63:0]               shifted,
  output logic [2*BYTE_LANES-1:0]   mask
);

  logic [31:0]           masked;
  logic [BYTE_LANES-1:0] lanes;

  // Reserved size yields no data and no lanes; the top rejects it separately.
  always_comb begin
    masked = '0;
    lanes  = '0;
    case (size)
      SZ_B: begin
        masked = {24'b0, data[7:0]};
        lanes  = 4'b0001;
      end
      SZ_H: begin
        masked = {16'b0, data[15:0]};
        lanes  = 4'b0011;
      end
      SZ_W: begin
        masked = data;
        lanes  = 4'b1111;
      end
      default: ;
    endcase
    shifted = {32'b0, masked} << {off, 3'b000};
    mask    = {{BYTE_LANES{1'b0}}, lanes} << off;
  end

endmodule

// File: rtl/store_unit.sv
// Store path: places store data on the memory write port with byte enables.
// Define STORE_MISALIGN_SPLIT_EN to split word-crossing stores into two beats.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [1:0]            req_size,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  done,
  output logic                  fault
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_BEAT0 = BEAT0;
`ifdef STORE_MISALIGN_SPLIT_EN
  localparam logic [1:0] ST_BEAT1 = BEAT1;
`endif

  logic [1:0]  state;
  logic [63:0] shifted;
  logic [7:0]  mask;
  logic        illegal;

  store_lane_align u_align (
    .size    (req_size),
    .off     (req_addr[1:0]),
    .data    (req_data),
    .shifted (shifted),
    .mask    (mask)
  );

  assign req_ready = (state == ST_IDLE);

`ifdef STORE_MISALIGN_SPLIT_EN
  logic [31:0] hi_wdata;
  logic [3:0]  hi_be;

  assign illegal = (req_size == 2'b11);
`else
  logic unused_hi;

  // Without splitting, the upper word image only matters through its mask.
  assign unused_hi = ^shifted[63:32];
  assign illegal   = (req_size == 2'b11) || (mask[7:4] != 4'b0000);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      hi_wdata  <= '0;
      hi_be     <= '0;
`endif
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              fault <= 1'b1;
            end else begin
              state     <= ST_BEAT0;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata <= shifted[31:0];
              mem_be    <= mask[3:0];
`ifdef STORE_MISALIGN_SPLIT_EN
              hi_wdata  <= shifted[63:32];
              hi_be     <= mask[7:4];
`endif
            end
          end
        end
        ST_BEAT0: begin
          if (mem_ready) begin
`ifdef STORE_MISALIGN_SPLIT_EN
            if (hi_be != 4'b0000) begin
              state     <= ST_BEAT1;
              mem_addr  <= mem_addr + ADDR_WIDTH'(4);
              mem_wdata <= hi_wdata;
              mem_be    <= hi_be;
            end else
`endif
            begin
              state     <= ST_IDLE;
              mem_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
`ifdef STORE_MISALIGN_SPLIT_EN
        ST_BEAT1: begin
          if (mem_ready) begin
            state     <= ST_IDLE;
            mem_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Directed table-driven bench for store_unit; expectations follow the
// STORE_MISALIGN_SPLIT_EN setting of the build.
module tb_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        fault;

  int compared;
  int mismatched;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          stall;
    bit          fault;
    logic [31:0] b0a;
    logic [31:0] b0d;
    logic [3:0]  b0e;
    bit          two;
    logic [31:0] b1a;
    logic [31:0] b1d;
    logic [3:0]  b1e;
  } vec_t;

  vec_t vecs[$];

  store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, input int st, input bit f,
                              input logic [31:0] b0a, input logic [31:0] b0d,
                              input logic [3:0] b0e, input bit two,
                              input logic [31:0] b1a, input logic [31:0] b1d,
                              input logic [3:0] b1e);
    vec_t v;
    v.addr = a;  v.data = d;  v.size = s;  v.stall = st;  v.fault = f;
    v.b0a = b0a; v.b0d = b0d; v.b0e = b0e; v.two = two;
    v.b1a = b1a; v.b1d = b1d; v.b1e = b1e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one request from accept to done (or fault) and checks every cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    nextCycle();
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
    mem_ready = 1'b0;
    checkOutput({t, ".ready_pre"}, 32'(req_ready), 32'd1);
    nextCycle();
    req_valid = 1'b0;
    if (v.fault) begin
      checkOutput({t, ".fault"}, 32'(fault), 32'd1);
      checkOutput({t, ".valid_f"}, 32'(mem_valid), 32'd0);
      checkOutput({t, ".ready_f"}, 32'(req_ready), 32'd1);
      nextCycle();
      checkOutput({t, ".fault_end"}, 32'(fault), 32'd0);
      checkOutput({t, ".done_f"}, 32'(done), 32'd0);
      checkOutput({t, ".valid_f2"}, 32'(mem_valid), 32'd0);
      return;
    end
    for (int k = 0; k <= v.stall; k++) begin
      mem_ready = (k == v.stall);
      checkOutput({t, ".b0_valid"}, 32'(mem_valid), 32'd1);
      checkOutput({t, ".b0_addr"}, mem_addr, v.b0a);
      checkOutput({t, ".b0_wdata"}, mem_wdata, v.b0d);
      checkOutput({t, ".b0_be"}, 32'(mem_be), 32'(v.b0e));
      checkOutput({t, ".b0_done"}, 32'(done), 32'd0);
      nextCycle();
    end
    if (v.two) begin
      checkOutput({t, ".b1_valid"}, 32'(mem_valid), 32'd1);
      checkOutput({t, ".b1_addr"}, mem_addr, v.b1a);
      checkOutput({t, ".b1_wdata"}, mem_wdata, v.b1d);
      checkOutput({t, ".b1_be"}, 32'(mem_be), 32'(v.b1e));
      checkOutput({t, ".b1_done"}, 32'(done), 32'd0);
      nextCycle();
    end
    checkOutput({t, ".done"}, 32'(done), 32'd1);
    checkOutput({t, ".valid_done"}, 32'(mem_valid), 32'd0);
    checkOutput({t, ".ready_done"}, 32'(req_ready), 32'd1);
    mem_ready = 1'b0;
    nextCycle();
    checkOutput({t, ".done_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit split;
`ifdef STORE_MISALIGN_SPLIT_EN
    split = 1'b1;
`else
    split = 1'b0;
`endif
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_size   = '0;
    mem_ready  = 1'b0;

    vecs.push_back(mk(32'h100, 32'hDEADBEEF, 2'b10, 0, 0, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0));
    vecs.push_back(mk(32'h203, 32'h123456AB, 2'b00, 0, 0, 32'h200, 32'hAB000000, 4'h8, 0, 0, 0, 0));
    vecs.push_back(mk(32'h302, 32'h0000BEEF, 2'b01, 3, 0, 32'h300, 32'hBEEF0000, 4'hC, 0, 0, 0, 0));
    vecs.push_back(mk(32'h401, 32'h11223344, 2'b10, 0, !split, 32'h400, 32'h22334400, 4'hE, split, 32'h404, 32'h00000011, 4'h1));
    vecs.push_back(mk(32'h500, 32'h11223344, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(32'h001, 32'hFFFFFF5A, 2'b00, 0, 0, 32'h000, 32'h00005A00, 4'h2, 0, 0, 0, 0));
    vecs.push_back(mk(32'h001, 32'hABCD1234, 2'b01, 1, 0, 32'h000, 32'h00123400, 4'h6, 0, 0, 0, 0));
    vecs.push_back(mk(32'h7FF, 32'h0000CAFE, 2'b01, 0, !split, 32'h7FC, 32'hFE000000, 4'h8, split, 32'h800, 32'h000000CA, 4'h1));
    vecs.push_back(mk(32'hFFFFFFFE, 32'hA1B2C3D4, 2'b10, 0, !split, 32'hFFFFFFFC, 32'hC3D40000, 4'hC, split, 32'h0, 32'h0000A1B2, 4'h3));
    vecs.push_back(mk(32'h000, 32'h00000077, 2'b00, 0, 0, 32'h000, 32'h00000077, 4'h1, 0, 0, 0, 0));

    // Outputs while held in reset.
    #2;
    checkOutput("rst.ready", 32'(req_ready), 32'd1);
    checkOutput("rst.valid", 32'(mem_valid), 32'd0);
    checkOutput("rst.addr", mem_addr, 32'd0);
    checkOutput("rst.wdata", mem_wdata, 32'd0);
    checkOutput("rst.be", 32'(mem_be), 32'd0);
    checkOutput("rst.done", 32'(done), 32'd0);
    checkOutput("rst.fault", 32'(fault), 32'd0);
    nextCycle();
    rst_n = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // A new request accepted on the done cycle still leaves an idle gap.
    nextCycle();
    req_valid = 1'b1; req_addr = 32'h100; req_data = 32'hDEADBEEF; req_size = 2'b10;
    nextCycle();
    req_valid = 1'b0; mem_ready = 1'b1;
    checkOutput("b2b.valid0", 32'(mem_valid), 32'd1);
    nextCycle();
    checkOutput("b2b.done0", 32'(done), 32'd1);
    checkOutput("b2b.gap", 32'(mem_valid), 32'd0);
    checkOutput("b2b.ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = 32'h203; req_data = 32'h123456AB; req_size = 2'b00;
    nextCycle();
    req_valid = 1'b0;
    checkOutput("b2b.valid1", 32'(mem_valid), 32'd1);
    checkOutput("b2b.addr1", mem_addr, 32'h200);
    checkOutput("b2b.be1", 32'(mem_be), 32'h8);
    nextCycle();
    checkOutput("b2b.done1", 32'(done), 32'd1);
    mem_ready = 1'b0;
    nextCycle();

    // Reset in the middle of a stalled transaction.
    req_valid = 1'b1;
`ifdef STORE_MISALIGN_SPLIT_EN
    req_addr = 32'h401; req_data = 32'h11223344; req_size = 2'b10;
    nextCycle();
    req_valid = 1'b0; mem_ready = 1'b1;
    checkOutput("mid.b0_valid", 32'(mem_valid), 32'd1);
    nextCycle();
    mem_ready = 1'b0;
    checkOutput("mid.b1_addr", mem_addr, 32'h404);
    nextCycle();
    checkOutput("mid.b1_hold", 32'(mem_be), 32'h1);
`else
    req_addr = 32'h100; req_data = 32'hDEADBEEF; req_size = 2'b10;
    nextCycle();
    req_valid = 1'b0;
    checkOutput("mid.b0_valid", 32'(mem_valid), 32'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid.valid_async", 32'(mem_valid), 32'd0);
    checkOutput("mid.ready_rst", 32'(req_ready), 32'd1);
    nextCycle();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("mid.no_done", 32'(done), 32'd0);
      checkOutput("mid.no_valid", 32'(mem_valid), 32'd0);
      checkOutput("mid.ready", 32'(req_ready), 32'd1);
      nextCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
